audio_note_player: RTL and testbench
====================================

// Module: audio_note_player
// PURPOSE
//  Melody sequencer and square-wave tone generator for the audio path. It sits downstream of the
//  clock divider: runs on clock_40MHz, samples the divider's clock_10Hz as a tempo tick, and steps
//  through an internal 16-entry song table.
//  Drives a 1-bit square wave (audio_out) to the speaker/buzzer pin plus status for the display.
// PARAMETERS
//  SONG_LEN  16  entries played from table, 1..16; index wraps/ends at SONG_LEN-1
//  GAP_EN    1   1: one silent tick (GAP) between notes; 0: notes play back-to-back
// PORTS
//  clock_40MHz  in   1  sole clock, 40 MHz
//  reset        in   1  asynchronous, active-high; clears all state
//  clock_10Hz   in   1  tempo source from divider, synchronous to clock_40MHz; rising edge = tick
//  play         in   1  level; 1 starts/continues playback, 0 stops immediately
//  loop         in   1  1: after last entry return to index 0; 0: finish and go IDLE
//  audio_out    out  1  square wave at current note frequency; 0 during rest/gap/idle
//  note_index   out  4  table index being played
//  note_code    out  4  code of current entry (0 when IDLE)
//  busy         out  1  1 in PLAY or GAP
//  done         out  1  one-cycle pulse when song ends with loop=0
// BEHAVIOUR
//  Reset: state IDLE; audio_out=0, note_index=0, note_code=0, busy=0, done=0, all counters 0.
//  Tick: clock_10Hz registered twice; tick = q1 & ~q2 (one clock_40MHz cycle per rising edge).
//  Note codes -> half period HP (17-bit, clock_40MHz cycles): 1=C4 76445, 2=D4 68106, 3=E4 60674,
//   4=F4 57269, 5=G4 51020, 6=A4 45455, 7=B4 40496, 8=C5 38223; 0 and 9..15 = rest.
//  Table entry = {code[3:0], dur[3:0]}; dur in ticks, dur=0 treated as 1.
//   Idx 0-7: codes 1..8 dur 2; idx 8: code 0 dur 4; idx 9-15: codes 7..1 dur 2.
//  FSM states IDLE, PLAY, GAP:
//   IDLE: play=1 -> PLAY next cycle, note_index=0, dur_cnt=dur, tone_cnt=0, audio_out=0.
//     A tick coincident with the start cycle is not counted.
//   PLAY: tone_cnt counts 0..HP-1; at HP-1 wraps to 0 and audio_out toggles (period 2*HP).
//     Rest code: audio_out=0, tone_cnt held 0. On tick: dur_cnt-1; tick with dur_cnt==1 ends note
//     -> GAP (GAP_EN=1) else advance directly.
//   GAP: audio_out=0; on next tick advance.
//   Advance: idx<SONG_LEN-1 -> idx+1, PLAY, reload dur, tone_cnt=0, audio_out=0.
//     idx==SONG_LEN-1 & loop=1 -> idx 0, PLAY. idx==SONG_LEN-1 & loop=0 -> IDLE, done=1 one cycle.
//   loop is sampled at the advance cycle only.
//  play=0 in PLAY/GAP: IDLE next cycle, audio_out=0, note_index=0, no done pulse. Overrides tick.
//  busy=1 exactly in PLAY/GAP; note_code reflects entry at note_index while busy.
//  Reset mid-operation: asynchronous return to reset values; playback restarts only on play=1.
// TESTING
//  1 Reset asserted mid-note -> same cycle audio_out=0, busy=0, note_index=0; stays until play=1.
//  2 play=1, drive clock_10Hz fast (toggle every 2000 cyc): idx0 audio_out toggles every 76445 cyc;
//    ends after 2 ticks; GAP 1 tick audio_out=0; idx1 toggles every 68106 cyc.
//  3 idx 8 rest: audio_out=0 for 4 ticks, note_code=0, busy=1; then GAP; idx 9 B4 HP=40496.
//  4 loop=0, full song -> after idx15 GAP tick: done=1 one cycle, busy=0, IDLE; GAP_EN=0: no gaps.
//  5 loop=1, SONG_LEN=4 -> after idx3 GAP tick: note_index=0, PLAY, done never asserts.
//  6 play dropped mid-note idx5 -> next cycle IDLE, audio_out=0, note_index=0, no done; replay idx0.

Source files
------------

// File: rtl/audio_note_player.sv
// Melody sequencer: steps a 16-entry song table on clock_10Hz rising edges and
// drives a square wave whose half period is set by the current note code.
module audio_note_player #(
    parameter int SONG_LEN = 16,
    parameter bit GAP_EN   = 1'b1
) (
    input  logic       clock_40MHz,
    input  logic       reset,
    input  logic       clock_10Hz,
    input  logic       play,
    input  logic       loop,
    output logic       audio_out,
    output logic [3:0] note_index,
    output logic [3:0] note_code,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
    localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

    // Table entry {code, dur}: rising scale, one long rest, falling scale.
    function automatic logic [7:0] f_entry(input logic [3:0] idx);
        logic [7:0] e;
        case (idx)
            4'd0:  e = {4'd1, 4'd2};
            4'd1:  e = {4'd2, 4'd2};
            4'd2:  e = {4'd3, 4'd2};
            4'd3:  e = {4'd4, 4'd2};
            4'd4:  e = {4'd5, 4'd2};
            4'd5:  e = {4'd6, 4'd2};
            4'd6:  e = {4'd7, 4'd2};
            4'd7:  e = {4'd8, 4'd2};
            4'd8:  e = {4'd0, 4'd4};
            4'd9:  e = {4'd7, 4'd2};
            4'd10: e = {4'd6, 4'd2};
            4'd11: e = {4'd5, 4'd2};
            4'd12: e = {4'd4, 4'd2};
            4'd13: e = {4'd3, 4'd2};
            4'd14: e = {4'd2, 4'd2};
            default: e = {4'd1, 4'd2};
        endcase
        return e;
    endfunction

    function automatic logic [3:0] f_code(input logic [3:0] idx);
        logic [7:0] e;
        e = f_entry(idx);
        return e[7:4];
    endfunction

    function automatic logic [3:0] f_dur(input logic [3:0] idx);
        logic [7:0] e;
        e = f_entry(idx);
        return (e[3:0] == 4'd0) ? 4'd1 : e[3:0];
    endfunction

    // Zero half period marks a rest.
    function automatic logic [16:0] f_half_period(input logic [3:0] code);
        case (code)
            4'd1:    return 17'd76445;
            4'd2:    return 17'd68106;
            4'd3:    return 17'd60674;
            4'd4:    return 17'd57269;
            4'd5:    return 17'd51020;
            4'd6:    return 17'd45455;
            4'd7:    return 17'd40496;
            4'd8:    return 17'd38223;
            default: return 17'd0;
        endcase
    endfunction

    state_t      r_state;
    logic        r_q1, r_q2, r_audio, r_done;
    logic [3:0]  r_idx, r_dur;
    logic [16:0] r_tone;
    logic        w_tick, w_last, w_rest, w_adv, w_busy;
    logic [3:0]  w_code, w_next_idx;
    logic [16:0] w_hp;

    assign w_tick     = r_q1 & ~r_q2;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_next_idx = w_last ? 4'd0 : r_idx + 4'd1;
    assign w_code     = f_code(r_idx);
    assign w_hp       = f_half_period(w_code);
    assign w_rest     = (w_hp == 17'd0);
    assign w_busy     = (r_state != IDLE);
    // Advance leaves the current entry: tick in GAP, or last tick of a note when gaps are off.
    assign w_adv = play & w_tick &
                   ((r_state == GAP) | ((r_state == PLAY) & (r_dur <= 4'd1) & ~GAP_EN));

    always_ff @(posedge clock_40MHz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_q1    <= 1'b0;
            r_q2    <= 1'b0;
            r_audio <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= 4'd0;
            r_dur   <= 4'd0;
            r_tone  <= 17'd0;
        end else begin
            r_q1   <= clock_10Hz;
            r_q2   <= r_q1;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_idx   <= 4'd0;
                    r_audio <= 1'b0;
                    r_tone  <= 17'd0;
                    if (play) begin
                        r_state <= PLAY;
                        r_dur   <= f_dur(4'd0);
                    end
                end
                default: begin
                    if (!play) begin
                        r_state <= IDLE;
                        r_idx   <= 4'd0;
                        r_audio <= 1'b0;
                        r_tone  <= 17'd0;
                    end else if (w_adv) begin
                        r_audio <= 1'b0;
                        r_tone  <= 17'd0;
                        if (w_last && !loop) begin
                            r_state <= IDLE;
                            r_idx   <= 4'd0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= PLAY;
                            r_idx   <= w_next_idx;
                            r_dur   <= f_dur(w_next_idx);
                        end
                    end else if (r_state == PLAY) begin
                        if (w_tick && r_dur <= 4'd1) begin
                            r_state <= GAP;
                            r_audio <= 1'b0;
                            r_tone  <= 17'd0;
                        end else begin
                            if (w_tick) r_dur <= r_dur - 4'd1;
                            if (w_rest) begin
                                r_tone  <= 17'd0;
                                r_audio <= 1'b0;
                            end else if (r_tone >= w_hp - 17'd1) begin
                                r_tone  <= 17'd0;
                                r_audio <= ~r_audio;
                            end else begin
                                r_tone <= r_tone + 17'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign audio_out  = r_audio;
    assign note_index = r_idx;
    assign note_code  = w_busy ? w_code : 4'd0;
    assign busy       = w_busy;
    assign done       = r_done;
endmodule

// File: tb/tb_audio_note_player.sv
// Bench for audio_note_player: three instances (default, no gaps, 4-entry loop)
// checked every cycle against a note-level playback model.
`timescale 1ns/1ps
module tb_audio_note_player;
    logic clk = 1'b0;
    logic rst, play, loop;
    logic c10 = 1'b0;
    int   tick_half;
    int   tcnt = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Tempo source: toggles every tick_half cycles, frozen when tick_half == 0.
    always @(negedge clk) begin
        if (tick_half != 0) begin
            if (tcnt + 1 >= tick_half) begin
                c10  = ~c10;
                tcnt = 0;
            end else begin
                tcnt++;
            end
        end
    end

    typedef struct packed {
        bit busy;
        bit gap;
        bit done;
        int idx;
        int left;
        int age;
        bit s1;
        bit s2;
    } mdl_t;

    function automatic int mcode(int i);
        return (i < 8) ? i + 1 : ((i == 8) ? 0 : 16 - i);
    endfunction

    function automatic int mdur(int i);
        return (i == 8) ? 4 : 2;
    endfunction

    function automatic int mhp(int code);
        case (code)
            1: return 76445;
            2: return 68106;
            3: return 60674;
            4: return 57269;
            5: return 51020;
            6: return 45455;
            7: return 40496;
            8: return 38223;
            default: return 0;
        endcase
    endfunction

    function automatic mdl_t mstep(mdl_t m, int len, bit gap_en, logic c10_i, logic play_i,
                                   logic loop_i);
        mdl_t n;
        bit   tick, adv;
        n = m;
        tick = m.s1 && !m.s2;
        n.s2 = m.s1;
        n.s1 = c10_i;
        n.done = 0;
        n.age = m.age + 1;
        adv = 0;
        if (!m.busy) begin
            if (play_i) begin
                n.busy = 1; n.gap = 0; n.idx = 0; n.left = mdur(0); n.age = 0;
            end
        end else if (!play_i) begin
            n.busy = 0; n.gap = 0; n.idx = 0;
        end else if (tick) begin
            if (m.gap || (m.left == 1 && !gap_en)) adv = 1;
            else if (m.left == 1) n.gap = 1;
            else n.left = m.left - 1;
        end
        if (adv) begin
            n.gap = 0;
            n.age = 0;
            if (m.idx < len - 1) begin
                n.idx = m.idx + 1; n.left = mdur(n.idx);
            end else if (loop_i) begin
                n.idx = 0; n.left = mdur(0);
            end else begin
                n.busy = 0; n.idx = 0; n.done = 1;
            end
        end
        return n;
    endfunction

    // Expected {audio, index, code, busy, done}; tone phase is age / half-period.
    function automatic logic [10:0] mexp(mdl_t m);
        int code;
        bit aud;
        code = m.busy ? mcode(m.idx) : 0;
        aud  = m.busy && !m.gap && code != 0 && ((m.age / mhp(code)) % 2 == 1);
        return {aud, 4'(m.idx), 4'(code), m.busy, m.done};
    endfunction

    logic [10:0] obs_v [3];
    logic [10:0] exp_v [3];
    logic        m_gap [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       a, b, d;
        logic [3:0] ni, nc;
        mdl_t       m;
        audio_note_player #(
            .SONG_LEN ((g == 2) ? 4 : 16),
            .GAP_EN   ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clock_40MHz (clk),
            .reset       (rst),
            .clock_10Hz  (c10),
            .play        (play),
            .loop        (loop),
            .audio_out   (a),
            .note_index  (ni),
            .note_code   (nc),
            .busy        (b),
            .done        (d)
        );
        always @(posedge clk or posedge rst) begin
            if (rst) m <= '0;
            else     m <= mstep(m, (g == 2) ? 4 : 16, (g == 1) ? 1'b0 : 1'b1, c10, play, loop);
        end
        assign obs_v[g] = {a, ni, nc, b, d};
        assign exp_v[g] = mexp(m);
        assign m_gap[g] = m.gap;
    end

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs_v[g] !== 11'd0) begin
                $display("FAIL reset_state u%0d: got %b want %b", g, obs_v[g], 11'd0);
                fails++;
            end
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g] || obs_v[g][1] !== 1'b0) begin
                    if (fails < 20) $display("FAIL idle_after_reset u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
            end
        end
    endtask

    task automatic test_tone();
        int n, tog;
        logic prev;
        loop = 1'b1;
        play = 1'b1;
        tick_half = $urandom_range(2, 4);
        n = 0;
        while (n < 2000 && !(exp_v[0][9:6] == 4'd7 && exp_v[0][1] && !m_gap[0])) begin
            @(negedge clk);
            n++;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g]) begin
                    if (fails < 20) $display("FAIL tone_seek u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
            end
        end
        checks++;
        if (n >= 2000) begin
            $display("FAIL tone_reach: idx7 not reached after %0d cycles, want < 2000", n);
            fails++;
        end
        tick_half = 0;
        tog = 0;
        prev = obs_v[0][10];
        repeat (39000) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g]) begin
                    if (fails < 20) $display("FAIL tone_hold u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
            end
            if (obs_v[0][10] !== prev) tog++;
            prev = obs_v[0][10];
        end
        checks++;
        if (tog != 1) begin
            $display("FAIL tone_toggles: got %0d toggles want 1", tog);
            fails++;
        end
    endtask

    task automatic test_rest();
        int n, rest_n;
        tick_half = $urandom_range(1, 4);
        n = 0;
        rest_n = 0;
        while (n < 3000 && exp_v[0][9:6] != 4'd9) begin
            @(negedge clk);
            n++;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g]) begin
                    if (fails < 20) $display("FAIL rest_run u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
            end
            if (exp_v[0][9:6] == 4'd8 && exp_v[0][1] && !m_gap[0]) begin
                rest_n++;
                checks++;
                if (obs_v[0][10] !== 1'b0 || obs_v[0][5:2] !== 4'd0 || obs_v[0][1] !== 1'b1) begin
                    $display("FAIL rest_note: got audio=%b code=%0d busy=%b want 0 0 1",
                             obs_v[0][10], obs_v[0][5:2], obs_v[0][1]);
                    fails++;
                end
            end
        end
        checks++;
        if (n >= 3000 || rest_n < 8) begin
            $display("FAIL rest_reach: got %0d rest cycles in %0d cycles want >= 8", rest_n, n);
            fails++;
        end
    endtask

    task automatic test_song_end();
        int n, dn, post;
        bit seen;
        loop = 1'b0;
        tick_half = $urandom_range(1, 4);
        n = 0; dn = 0; post = 0; seen = 0;
        while (n < 3000 && post < 20) begin
            @(negedge clk);
            n++;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g]) begin
                    if (fails < 20) $display("FAIL song_end u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
            end
            if (obs_v[0][0]) dn++;
            if (exp_v[0][0]) seen = 1;
            if (seen) post++;
        end
        checks++;
        if (!seen || dn != 1) begin
            $display("FAIL done_pulse: got %0d pulses want 1 (end reached=%0d)", dn, seen);
            fails++;
        end
    endtask

    task automatic test_loop();
        int dn, wraps;
        logic [3:0] prev;
        loop = 1'b1;
        tick_half = $urandom_range(1, 4);
        dn = 0; wraps = 0;
        prev = obs_v[2][9:6];
        repeat (600) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g]) begin
                    if (fails < 20) $display("FAIL loop_run u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
                if (obs_v[g][0]) dn++;
            end
            if (prev == 4'd3 && obs_v[2][9:6] == 4'd0 && obs_v[2][1]) wraps++;
            prev = obs_v[2][9:6];
        end
        checks++;
        if (dn != 0 || wraps == 0) begin
            $display("FAIL loop_wrap: got %0d done pulses, %0d wraps want 0, >0", dn, wraps);
            fails++;
        end
    endtask

    task automatic test_play_drop();
        tick_half = $urandom_range(1, 4);
        repeat (6) begin
            repeat ($urandom_range(5, 60)) begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if (obs_v[g] !== exp_v[g]) begin
                        if (fails < 20) $display("FAIL drop_run u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                        fails++;
                    end
                end
            end
            play = 1'b0;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== 11'd0) begin
                    $display("FAIL play_drop u%0d: got %b want %b", g, obs_v[g], 11'd0);
                    fails++;
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            play = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        play = 1'b1;
        tick_half = $urandom_range(1, 4);
        repeat ($urandom_range(20, 200)) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g]) begin
                    if (fails < 20) $display("FAIL pre_reset u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
            end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs_v[g] !== 11'd0) begin
                $display("FAIL async_reset u%0d: got %b want %b", g, obs_v[g], 11'd0);
                fails++;
            end
        end
        @(negedge clk);
        play = 1'b0;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== 11'd0) begin
                    $display("FAIL stay_idle u%0d: got %b want %b", g, obs_v[g], 11'd0);
                    fails++;
                end
            end
        end
        play = 1'b1;
        repeat (100) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs_v[g] !== exp_v[g]) begin
                    if (fails < 20) $display("FAIL replay u%0d: got %b want %b", g, obs_v[g], exp_v[g]);
                    fails++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        play = 1'b0;
        loop = 1'b0;
        tick_half = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_tone();
        test_rest();
        test_song_end();
        test_loop();
        test_play_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
